// File: rtl/aes_iter_encrypt_ctrl_pkg.sv
// Shared types and AES byte/word primitives for the iterative encrypt sequencer.
// Pure functions only; no state lives here.
package aes_iter_encrypt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  function automatic int rcnt_width(input int nr);
    return $clog2(nr + 1);
  endfunction

  function automatic bit legal_cfg(input int n, input int nr, input int nk);
    return (n == 128 && nr == 10 && nk == 4) ||
           (n == 192 && nr == 12 && nk == 6) ||
           (n == 256 && nr == 14 && nk == 8);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = sbox(s[127-8*b -: 8]);
    return o;
  endfunction

  // Byte b = row + 4*col, first byte in the MSBs.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk);
    return mix_columns(shift_rows(sub_bytes(s))) ^ rk;
  endfunction

  function automatic logic [127:0] final_round(input logic [127:0] s, input logic [127:0] rk);
    return shift_rows(sub_bytes(s)) ^ rk;
  endfunction

endpackage

// File: rtl/aes_round_key_sel.sv
// Picks round key rk[round_cnt] out of the flattened expanded schedule (word 0 in the MSBs).
// Purely combinational.
module aes_round_key_sel #(
  parameter int Nr = 10,
  parameter int CW = 4
) (
  input  logic [128*(Nr+1)-1:0] fullkeys,
  input  logic [CW-1:0]         round_cnt,
  output logic [127:0]          rk
);

  always_comb begin
    rk = '0;
    for (int r = 0; r <= Nr; r++) begin
      if (int'(round_cnt) == r) rk = fullkeys[128*(Nr+1)-1-128*r -: 128];
    end
  end

endmodule

// File: rtl/aes_iter_encrypt_ctrl.sv
// Iterative AES encryptor: one round per clock over a shared datapath, out_valid Nr edges after accept.
// Single-block: in_ready only in IDLE, ciphertext held in DONE until out_ready.
module aes_iter_encrypt_ctrl
  import aes_iter_encrypt_ctrl_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in,
  input  logic [N-1:0]   key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out,
  output logic           busy
);

  localparam int CW = rcnt_width(Nr);
  localparam int NW = 4 * (Nr + 1);

  if (!legal_cfg(N, Nr, Nk)) begin : g_bad_cfg
    $error("aes_iter_encrypt_ctrl: illegal (N, Nr, Nk) combination");
  end

  fsm_e              fsm_q, fsm_d;
  logic [127:0]      state_q, state_d;
  logic [N-1:0]      key_q, key_d;
  logic [CW-1:0]     round_cnt_q, round_cnt_d;
  logic [128*NW/4-1:0] fullkeys;
  logic [127:0]      rk;
  logic              last_round;

  // Schedule is expanded from the registered key so the port may change mid-block.
  always_comb begin : key_expand
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rc;
    fullkeys = '0;
    rc = 8'h01;
    t  = '0;
    for (int i = 0; i < Nk; i++) begin
      w[i] = key_q[N-1-32*i -: 32];
      fullkeys[32*NW-1-32*i -: 32] = w[i];
    end
    for (int i = Nk; i < NW; i++) begin
      t = w[i-1];
      if (i % Nk == 0) begin
        t  = sub_word(rot_word(t)) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-Nk] ^ t;
      fullkeys[32*NW-1-32*i -: 32] = w[i];
    end
  end

  aes_round_key_sel #(
    .Nr (Nr),
    .CW (CW)
  ) u_rk_sel (
    .fullkeys  (fullkeys),
    .round_cnt (round_cnt_q),
    .rk        (rk)
  );

  assign last_round = (round_cnt_q == CW'(Nr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      key_q       <= '0;
      round_cnt_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      round_cnt_q <= round_cnt_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid) fsm_d = ROUND;
      ROUND:   if (last_round) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // rk[0] comes straight from the live key: the first four key words are round key 0.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    round_cnt_d = round_cnt_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          key_d       = key;
          state_d     = in ^ key[N-1 -: 128];
          round_cnt_d = CW'(1);
        end
      end
      ROUND: begin
        state_d     = last_round ? final_round(state_q, rk) : enc_round(state_q, rk);
        round_cnt_d = round_cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (fsm_q == IDLE);
    out_valid = (fsm_q == DONE);
    busy      = (fsm_q == ROUND) || (fsm_q == DONE);
    out       = state_q;
  end

endmodule

// File: tb/tb_aes_iter_encrypt_ctrl.sv
// Directed bench for the iterative AES encryptor: AES-128 instance plus an AES-256 instance,
// known-answer vectors, latency, back-pressure, streaming and mid-block reset.
module tb_aes_iter_encrypt_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic         sel;
  logic [127:0] din;
  logic [255:0] dkey;

  logic         rdy_a, vld_a, busy_a, rdy_b, vld_b, busy_b;
  logic [127:0] out_a, out_b;
  logic         obs_rdy, obs_vld, obs_busy;
  logic [127:0] obs_out;

  int checks = 0;
  int errors = 0;
  int lat;

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_S1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_S1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic [127:0] s_pt  [8];
  logic [127:0] s_key [8];
  logic [127:0] s_ct  [8];

  always #5 clk = ~clk;

  aes_iter_encrypt_ctrl #(.N(128), .Nr(10), .Nk(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && !sel),
    .in_ready  (rdy_a),
    .in        (din),
    .key       (dkey[255:128]),
    .out_valid (vld_a),
    .out_ready (out_ready && !sel),
    .out       (out_a),
    .busy      (busy_a)
  );

  aes_iter_encrypt_ctrl #(.N(256), .Nr(14), .Nk(8)) dut256 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && sel),
    .in_ready  (rdy_b),
    .in        (din),
    .key       (dkey),
    .out_valid (vld_b),
    .out_ready (out_ready && sel),
    .out       (out_b),
    .busy      (busy_b)
  );

  assign obs_rdy  = sel ? rdy_b  : rdy_a;
  assign obs_vld  = sel ? vld_b  : vld_a;
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_out  = sel ? out_b  : out_a;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [255:0] k);
    int n;
    n = 0;
    while (!obs_rdy && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", obs_rdy, 1);
    din      = pt;
    dkey     = k;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    din  = {$urandom, $urandom, $urandom, $urandom};
    dkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (!obs_vld && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [127:0] pt, input logic [255:0] k,
                         input logic [127:0] ct, input int exp_lat);
    int l;
    send(pt, k);
    wait_valid(l);
    chk({tag, "_latency"}, l, exp_lat);
    chk({tag, "_out"}, obs_out, ct);
    chk({tag, "_busy_done"}, obs_busy, 1);
    chk({tag, "_rdy_done"}, obs_rdy, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, obs_vld, 0);
    chk({tag, "_rdy_idle"}, obs_rdy, 1);
    chk({tag, "_busy_idle"}, obs_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hold_ok, rdy_ok, acc;
    int   idx_in, idx_out;

    s_pt[0] = PT_S1;                                   s_ct[0] = CT_S1;
    s_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;  s_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    s_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;  s_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
    s_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;  s_ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
    s_pt[4] = PT_C1;                                   s_ct[4] = CT_C1;
    s_pt[5] = PT_B;                                    s_ct[5] = CT_B;
    s_pt[6] = s_pt[2];                                 s_ct[6] = s_ct[2];
    s_pt[7] = PT_C1;                                   s_ct[7] = CT_C1;
    for (int i = 0; i < 8; i++) s_key[i] = (i == 4 || i == 7) ? KEY_C1 : KEY_B;

    sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0; dkey = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", obs_vld, 0);
    chk("rst_in_ready", obs_rdy, 1);
    chk("rst_busy", obs_busy, 0);
    chk("rst_out", obs_out, 128'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_vec("c1", PT_C1, {KEY_C1, 128'h0}, CT_C1, 10);
    run_vec("appb", PT_B, {KEY_B, 128'h0}, CT_B, 10);

    // Back-pressure: a competing request is presented throughout DONE.
    send(PT_C1, {KEY_C1, 128'h0});
    wait_valid(lat);
    chk("bp_latency", lat, 10);
    din = PT_S1; dkey = {KEY_B, 128'h0}; in_valid = 1'b1;
    hold_ok = 1'b1; rdy_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!obs_vld || obs_out !== CT_C1) hold_ok = 1'b0;
      if (obs_rdy) rdy_ok = 1'b0;
    end
    chk("bp_out_held", hold_ok, 1);
    chk("bp_in_ready_low", rdy_ok, 1);
    chk("bp_out_value", obs_out, CT_C1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_vld", obs_vld, 0);
    chk("bp_release_rdy", obs_rdy, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_accepted", obs_busy, 1);
    wait_valid(lat);
    chk("bp_second_latency", lat, 10);
    chk("bp_second_out", obs_out, CT_S1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Streaming with in_valid and out_ready both held high.
    idx_in = 0; idx_out = 0;
    din = s_pt[0]; dkey = {s_key[0], 128'h0};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && idx_out < 8; cyc++) begin
      acc = obs_rdy && in_valid;
      if (obs_vld) begin
        chk($sformatf("stream_out%0d", idx_out), obs_out, s_ct[idx_out]);
        idx_out++;
      end
      tick();
      if (acc) begin
        idx_in++;
        if (idx_in < 8) begin
          din = s_pt[idx_in]; dkey = {s_key[idx_in], 128'h0};
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("stream_count", idx_out, 8);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();

    // Reset while round_cnt is 5.
    send(PT_C1, {KEY_C1, 128'h0});
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_busy_before", obs_busy, 1);
    chk("midrst_vld_before", obs_vld, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", obs_vld, 0);
    chk("midrst_rdy", obs_rdy, 1);
    chk("midrst_busy", obs_busy, 0);
    chk("midrst_out", obs_out, 128'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_rdy_after", obs_rdy, 1);
    run_vec("c1_after_rst", PT_C1, {KEY_C1, 128'h0}, CT_C1, 10);

    // AES-256 instance.
    sel = 1'b1;
    tick();
    run_vec("c3", PT_C1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            128'h8ea2b7ca516745bfeafc49904b496089, 14);
    run_vec("ecb256", PT_S1, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
            128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
